// File: rtl/solve_position_multi.sv
// Ball-position integrator: fixed-point X/Y accumulation with wall bounce, arena clamp and win FSM.
// Optional macro DWELL_EN adds a SETTLE dwell of WIN_HOLD near steps before WIN.
module solve_position_multi #(
  parameter int INT_W    = 9,
  parameter int FRAC_W   = 7,
  parameter int VEL_W    = 11,
  parameter int OUT_W    = 11,
  parameter int WIN_DIST = 2,
  parameter int WIN_HOLD = 8,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 511,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 511
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    step,
  input  logic        [OUT_W-1:0] init_x,
  input  logic        [OUT_W-1:0] init_y,
  input  logic        [OUT_W-1:0] score_x,
  input  logic        [OUT_W-1:0] score_y,
  input  logic signed [VEL_W-1:0] velocity_x,
  input  logic signed [VEL_W-1:0] velocity_y,
  input  logic        [3:0]       collision,
  output logic        [OUT_W-1:0] position_x,
  output logic        [OUT_W-1:0] position_y,
  output logic        [3:0]       wall,
  output logic                    win,
  output logic        [1:0]       state
);

  localparam int ACC_W = INT_W + FRAC_W;
  localparam int SUM_W = ACC_W + 2;

  localparam logic signed [SUM_W-1:0] X_LO = SUM_W'(X_MIN * (2 ** FRAC_W));
  localparam logic signed [SUM_W-1:0] X_HI = SUM_W'(X_MAX * (2 ** FRAC_W) + (2 ** FRAC_W) - 1);
  localparam logic signed [SUM_W-1:0] Y_LO = SUM_W'(Y_MIN * (2 ** FRAC_W));
  localparam logic signed [SUM_W-1:0] Y_HI = SUM_W'(Y_MAX * (2 ** FRAC_W) + (2 ** FRAC_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2,
    S_WIN    = 2'd3
  } state_t;

  state_t             state_q;
  logic               win_q;
  logic [3:0]         wall_q;
  logic [ACC_W-1:0]   acc_x_q, acc_y_q;
  logic [ACC_W-1:0]   step_x_d, step_y_d;
  logic [ACC_W-1:0]   init_x_d, init_y_d;
  logic [ACC_W-1:0]   score_x_d, score_y_d;
  logic [3:0]         wall_d;
  logic               near_d;
  logic signed [SUM_W-1:0] sum_x, sum_y;
  logic               unused_init_hi;
`ifdef DWELL_EN
  logic [7:0]         cnt_q;
`endif

  // One axis update in SUM_W signed bits so no result can wrap before clamping.
  function automatic logic signed [SUM_W-1:0] step_sum(
    input logic [ACC_W-1:0] acc,
    input logic signed [VEL_W-1:0] v,
    input logic [1:0] rule
  );
    logic signed [SUM_W-1:0] a, vs, half;
    logic [VEL_W-1:0] mag;
    a    = $signed({2'b00, acc});
    vs   = $signed({{(SUM_W-VEL_W){v[VEL_W-1]}}, v});
    mag  = v[VEL_W-1] ? VEL_W'(-v) : VEL_W'(v);
    half = $signed({{(SUM_W-VEL_W){1'b0}}, (mag >> 1)});
    case (rule)
      2'b00:   step_sum = a + vs;
      2'b10:   step_sum = a + half;
      2'b01:   step_sum = a - half;
      default: step_sum = a;
    endcase
  endfunction

  function automatic logic [ACC_W-1:0] clamp(input logic signed [SUM_W-1:0] s, input logic is_y);
    if (s < (is_y ? Y_LO : X_LO))
      clamp = is_y ? Y_LO[ACC_W-1:0] : X_LO[ACC_W-1:0];
    else if (s > (is_y ? Y_HI : X_HI))
      clamp = is_y ? Y_HI[ACC_W-1:0] : X_HI[ACC_W-1:0];
    else
      clamp = s[ACC_W-1:0];
  endfunction

  function automatic logic near_axis(input logic [OUT_W-1:0] p, input logic [OUT_W-1:0] t);
    logic [OUT_W-1:0] d;
    d = (p >= t) ? (p - t) : (t - p);
    near_axis = (d <= OUT_W'(WIN_DIST));
  endfunction

  always_comb begin
    sum_x     = step_sum(acc_x_q, velocity_x, collision[1:0]);
    sum_y     = step_sum(acc_y_q, velocity_y, collision[3:2]);
    step_x_d  = clamp(sum_x, 1'b0);
    step_y_d  = clamp(sum_y, 1'b1);
    wall_d    = {sum_y > Y_HI, sum_y < Y_LO, sum_x > X_HI, sum_x < X_LO};
    init_x_d  = clamp($signed({2'b00, init_x[INT_W-1:0], {FRAC_W{1'b0}}}), 1'b0);
    init_y_d  = clamp($signed({2'b00, init_y[INT_W-1:0], {FRAC_W{1'b0}}}), 1'b1);
    score_x_d = clamp($signed({2'b00, score_x[INT_W-1:0], {FRAC_W{1'b0}}}), 1'b0);
    score_y_d = clamp($signed({2'b00, score_y[INT_W-1:0], {FRAC_W{1'b0}}}), 1'b1);
    near_d    = near_axis(OUT_W'(step_x_d[ACC_W-1:FRAC_W]), score_x) &&
                near_axis(OUT_W'(step_y_d[ACC_W-1:FRAC_W]), score_y);
  end

  assign unused_init_hi = ^{init_x, init_y};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= 1'b0;
      wall_q  <= 4'b0000;
      acc_x_q <= '0;
      acc_y_q <= '0;
`ifdef DWELL_EN
      cnt_q   <= 8'd0;
`endif
    end else if (start) begin
      // Restart path: start has priority over any step in the same cycle.
      state_q <= S_RUN;
      win_q   <= 1'b0;
      wall_q  <= 4'b0000;
      acc_x_q <= init_x_d;
      acc_y_q <= init_y_d;
`ifdef DWELL_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      case (state_q)
        S_RUN, S_SETTLE: begin
          if (step) begin
            acc_x_q <= step_x_d;
            acc_y_q <= step_y_d;
            wall_q  <= wall_d;
            if (near_d) begin
`ifdef DWELL_EN
              if (state_q == S_RUN && WIN_HOLD > 1) begin
                state_q <= S_SETTLE;
                cnt_q   <= 8'd1;
              end else if (state_q == S_SETTLE && (cnt_q + 8'd1) != 8'(WIN_HOLD)) begin
                cnt_q   <= cnt_q + 8'd1;
              end else begin
                state_q <= S_WIN;
                win_q   <= 1'b1;
                acc_x_q <= score_x_d;
                acc_y_q <= score_y_d;
              end
`else
              state_q <= S_WIN;
              win_q   <= 1'b1;
              acc_x_q <= score_x_d;
              acc_y_q <= score_y_d;
`endif
            end else begin
`ifdef DWELL_EN
              state_q <= S_RUN;
              cnt_q   <= 8'd0;
`endif
            end
          end
        end
        S_WIN: begin
          // Ball is pinned to the target, following it if it moves.
          acc_x_q <= score_x_d;
          acc_y_q <= score_y_d;
        end
        default: ;
      endcase
    end
  end

  assign position_x = OUT_W'(acc_x_q[ACC_W-1:FRAC_W]);
  assign position_y = OUT_W'(acc_y_q[ACC_W-1:FRAC_W]);
  assign wall       = wall_q;
  assign win        = win_q;
  assign state      = state_q;

endmodule
